// File: rtl/calc_control.sv
// Keypad-to-memory/ALU sequencer for a two-operand calculator; every output is registered.
// Latency: 1 cycle from an accepted key to its strobe; no backpressure, keys are dropped while busy.
module calc_control #(
  parameter int DIGITS_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       alu_done,
  output logic [3:0] num,
  output logic [1:0] operator,
  output logic [1:0] save_enable,
  output logic       op_enable,
  output logic       equ_enable,
  output logic       clear_enable,
  output logic       busy,
  output logic [2:0] state,
  output logic       err
);

  localparam int CW = $clog2(DIGITS_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OPA  = 3'd1,
    OPR  = 3'd2,
    OPB  = 3'd3,
    EXEC = 3'd4,
    DONE = 3'd5,
    PEND = 3'd6
  } state_t;

  state_t        cur_state, n_state;
  logic [CW-1:0] count, n_count;
  logic [TW-1:0] timer, n_timer;
  logic [3:0]    n_num;
  logic [1:0]    n_op, n_save;
  logic          n_op_en, n_equ_en, n_clr_en, n_err, n_busy;

  logic is_digit, is_oper, is_equ, is_clr, cnt_room;
  logic [1:0] key_op;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_oper  = key_valid && (key_code >= 4'hA) && (key_code <= 4'hD);
  assign is_equ   = key_valid && (key_code == 4'hE);
  assign is_clr   = key_valid && (key_code == 4'hF);
  assign cnt_room = count < CW'(DIGITS_MAX);
  // key_code - 0xA for A..D reduces to adding 2 to the low two bits
  assign key_op   = key_code[1:0] + 2'd2;

  assign state = cur_state;

  always_comb begin
    n_state  = cur_state;
    n_count  = count;
    n_timer  = timer;
    n_num    = num;
    n_op     = operator;
    n_save   = 2'b00;
    n_op_en  = 1'b0;
    n_equ_en = 1'b0;
    n_clr_en = 1'b0;
    n_err    = err;

    if (is_clr) begin
      n_clr_en = 1'b1;
      n_err    = 1'b0;
      n_count  = '0;
      n_state  = IDLE;
    end else begin
      unique case (cur_state)
        IDLE: if (is_digit) begin
          n_save  = 2'b01;
          n_num   = key_code;
          n_count = CW'(1);
          n_err   = 1'b0;
          n_state = OPA;
        end
        OPA: begin
          if (is_digit && cnt_room) begin
            n_save  = 2'b01;
            n_num   = key_code;
            n_count = count + CW'(1);
          end else if (is_oper) begin
            n_save  = 2'b10;
            n_op    = key_op;
            n_state = OPR;
          end
        end
        OPR: begin
          if (is_digit) begin
            n_save  = 2'b11;
            n_num   = key_code;
            n_count = CW'(1);
            n_state = OPB;
          end else if (is_oper) begin
            n_save = 2'b10;
            n_op   = key_op;
          end
        end
        OPB: begin
          if (is_digit && cnt_room) begin
            n_save  = 2'b11;
            n_num   = key_code;
            n_count = count + CW'(1);
          end else if (is_equ) begin
            n_equ_en = 1'b1;
            n_op_en  = 1'b1;
            n_timer  = '0;
            n_state  = EXEC;
          end
        end
        EXEC: begin
          if (alu_done) begin
            n_state = DONE;
          end else if (timer == TW'(TIMEOUT)) begin
            n_err    = 1'b1;
            n_clr_en = 1'b1;
            n_count  = '0;
            n_state  = IDLE;
          end else begin
            n_timer = timer + TW'(1);
          end
        end
        DONE: begin
          if (is_oper) begin
            n_save  = 2'b10;
            n_op    = key_op;
            n_state = OPR;
          end else if (is_digit) begin
            // the memory is cleared first; the held digit is written on the following cycle
            n_clr_en = 1'b1;
            n_num    = key_code;
            n_state  = PEND;
          end
        end
        PEND: begin
          n_save  = 2'b01;
          n_count = CW'(1);
          n_state = OPA;
        end
        default: n_state = IDLE;
      endcase
    end

    n_busy = (n_state == EXEC) || (n_state == PEND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state    <= IDLE;
      count        <= '0;
      timer        <= '0;
      num          <= '0;
      operator     <= '0;
      save_enable  <= 2'b00;
      op_enable    <= 1'b0;
      equ_enable   <= 1'b0;
      clear_enable <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      cur_state    <= n_state;
      count        <= n_count;
      timer        <= n_timer;
      num          <= n_num;
      operator     <= n_op;
      save_enable  <= n_save;
      op_enable    <= n_op_en;
      equ_enable   <= n_equ_en;
      clear_enable <= n_clr_en;
      busy         <= n_busy;
      err          <= n_err;
    end
  end

endmodule

// File: doc/calc_control.md
CALC_CONTROL -- requirements
Module: calc_control

Interface
REQ-001 The block SHALL have parameter DIGITS_MAX, default 4, meaning the maximum number of digits accepted per operand.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, meaning the number of EXEC cycles to wait for alu_done before aborting.
REQ-003 The block SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port key_valid  in  1  one-cycle pulse qualifying key_code.
REQ-006 The block SHALL have port key_code  in  4  0x0-0x9 digit; 0xA add, 0xB sub, 0xC mul, 0xD div; 0xE equals; 0xF clear.
REQ-007 The block SHALL have port alu_done  in  1  one-cycle pulse: result available on memory res.
REQ-008 The block SHALL have port num  out  4  digit driven to memory.
REQ-009 The block SHALL have port operator  out  2  operator code (key_code-0xA) driven to memory.
REQ-010 The block SHALL have port save_enable  out  2  meaning 01 = append digit to save1, 11 = append digit to save2, 10 = store operator, 00 = idle.
REQ-011 The block SHALL have ports op_enable, equ_enable and clear_enable  out  1 each  one-cycle strobes to memory/ALU.
REQ-012 The block SHALL have port busy  out  1  high while keys are being dropped (EXEC, pending-digit cycle).
REQ-013 The block SHALL have port state  out  3  current FSM state encoding.
REQ-014 The block SHALL have port err  out  1  sticky ALU-timeout flag.

Function
REQ-015 The FSM states SHALL be encoded IDLE=0, OPA=1, OPR=2, OPB=3, EXEC=4, DONE=5, PEND=6.
REQ-016 All outputs SHALL be registered; every strobe SHALL be asserted exactly one cycle, in the cycle after the accepting key_valid. save_enable SHALL return to 00 otherwise.
REQ-017 The clear key SHALL be accepted in every state: clear_enable pulse, err<=0, digit count<=0, next state IDLE.
REQ-018 In IDLE, a digit SHALL produce save_enable=01 with num=digit, set count=1, clear err, and move to OPA; operator and equals keys SHALL be ignored.
REQ-019 In OPA, a digit with count<DIGITS_MAX SHALL produce save_enable=01 and count+1; a digit at count=DIGITS_MAX SHALL be ignored; an operator SHALL produce save_enable=10 with its operator code and move to OPR; equals SHALL be ignored.
REQ-020 In OPR, a digit SHALL produce save_enable=11, set count=1, and move to OPB; an operator SHALL re-store the operator (save_enable=10) and remain in OPR; equals SHALL be ignored.
REQ-021 In OPB, digits SHALL append with save_enable=11 under the same DIGITS_MAX rule; equals SHALL pulse equ_enable and op_enable together, reset the timer to 0, and move to EXEC; operators SHALL be ignored.
REQ-022 In EXEC, alu_done SHALL move the FSM to DONE. Otherwise, when the timer reaches TIMEOUT, the block SHALL set err=1, pulse clear_enable, and move to IDLE. Non-clear keys SHALL be dropped.
REQ-023 If key_valid and alu_done coincide in EXEC, alu_done SHALL win and the key SHALL be dropped, unless the key is clear, in which case clear wins.
REQ-024 In DONE, an operator SHALL produce save_enable=10 and move to OPR, chaining on the result. A digit SHALL pulse clear_enable, latch the digit, and move to PEND. Equals SHALL be ignored.
REQ-025 PEND SHALL last exactly one cycle: save_enable=01 with the latched num, count=1, then OPA; a key arriving in PEND SHALL be dropped.
REQ-026 clear_enable and save_enable!=00 SHALL never be asserted in the same cycle.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL set state=IDLE and all outputs to 0 (num, operator, save_enable, strobes, busy, err), and clear count and timer.
REQ-028 A reset during EXEC or PEND SHALL abort without emitting any strobe.

Verification
REQ-029 Keys 1,2,A,3,E, then alu_done 3 cycles later SHALL give: save_enable 01,01,10,11; operator=00; num 1,2,3; equ_enable+op_enable one pulse; state sequence 1,2,3,4,5.
REQ-030 In OPA, six digits with DIGITS_MAX=4 SHALL give exactly 4 save_enable=01 pulses; the 5th and 6th digits SHALL produce no output.
REQ-031 In EXEC with no alu_done SHALL give: err=1 and clear_enable pulse at timer=15, state=IDLE; a subsequent digit SHALL clear err.
REQ-032 DONE then digit 7 SHALL give: clear_enable in cycle N, save_enable=01 with num=7 in cycle N+1, and no overlap of the two.
REQ-033 Key and alu_done in the same EXEC cycle SHALL give DONE with the key dropped; clear with alu_done SHALL give IDLE.
REQ-034 rst asserted mid-EXEC SHALL give all outputs 0 and state 0 on the next edge, with no strobe.
